// File: rtl/nios_pio_pkg.sv
// Shared constants and types for the nios_pio_irq GPIO peripheral.
// Optional input synchroniser is enabled with the PIO_IN_SYNC_EN macro.
package nios_pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   typedef struct packed {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] data;
   } pio_req_t;

   // Single-bit edge test for the configured edge type.
   function automatic logic edge_bit(input int edge_type, input logic cur, input logic prv);
      case (edge_type)
         EDGE_FALL: edge_bit = ~cur & prv;
         EDGE_ANY:  edge_bit = cur ^ prv;
         default:   edge_bit = cur & ~prv;
      endcase
   endfunction

endpackage

// File: rtl/nios_pio_edge_det.sv
// Input path: optional two-flop synchroniser (PIO_IN_SYNC_EN), previous-value
// register, priming flag and per-bit edge detection.
module nios_pio_edge_det
   import nios_pio_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int EDGE_TYPE = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] in_s,
   output logic [WIDTH-1:0] edge_det
);

`ifdef PIO_IN_SYNC_EN
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   assign in_s = sync2;
`else
   assign in_s = in_port;
`endif

   logic [WIDTH-1:0] prev;
   logic             primed;

   // primed masks the bogus edge seen against prev's reset value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev   <= '0;
         primed <= 1'b0;
      end else begin
         prev   <= in_s;
         primed <= 1'b1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign edge_det[i] = primed & edge_bit(EDGE_TYPE, in_s[i], prev[i]);
   end

endmodule

// File: rtl/nios_pio_irq.sv
// Avalon-MM GPIO with direction control, set/clear strobes, edge capture and
// maskable level irq. Define PIO_IN_SYNC_EN to synchronise in_port.
module nios_pio_irq
   import nios_pio_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_OUT = '0,
   parameter logic [WIDTH-1:0] RESET_DIR = '0,
   parameter int               EDGE_TYPE = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   pio_req_t         req;
   logic [WIDTH-1:0] wdata;
   logic             unused_wdata;

   assign req.wr       = chipselect & ~write_n;
   assign req.addr     = address;
   assign req.data     = writedata;
   assign wdata        = req.data[WIDTH-1:0];
   assign unused_wdata = ^writedata;

   logic [WIDTH-1:0] in_s;
   logic [WIDTH-1:0] edge_det;

   nios_pio_edge_det #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (EDGE_TYPE)
   ) u_edge (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_port  (in_port),
      .in_s     (in_s),
      .edge_det (edge_det)
   );

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] rd_mux;

   assign cap_clr = (req.wr && req.addr == ADDR_EDGECAP) ? wdata : '0;

   always_comb begin
      rd_mux = '0;
      case (req.addr)
         ADDR_DATA:    rd_mux = (dir & data_out) | (~dir & in_s);
         ADDR_DIR:     rd_mux = dir;
         ADDR_IRQMASK: rd_mux = irqmask;
         ADDR_EDGECAP: rd_mux = edgecap;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= RESET_OUT;
         dir      <= RESET_DIR;
         irqmask  <= '0;
         edgecap  <= '0;
         readdata <= '0;
      end else begin
         if (req.wr) begin
            case (req.addr)
               ADDR_DATA:    data_out <= wdata;
               ADDR_DIR:     dir      <= wdata;
               ADDR_IRQMASK: irqmask  <= wdata;
               ADDR_OUTSET:  data_out <= data_out | wdata;
               ADDR_OUTCLR:  data_out <= data_out & ~wdata;
               default:      ;
            endcase
         end
         // A new edge overrides a same-cycle software clear.
         edgecap  <= (edgecap & ~cap_clr) | edge_det;
         readdata <= 32'(rd_mux);
      end
   end

   assign out_port = data_out;
   assign oe       = dir;
   assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_pio_irq.sv
// Directed bench for nios_pio_irq with a per-cycle behavioural reference model.
module tb_nios_pio_irq;
   import nios_pio_pkg::*;

   localparam int             W     = 8;
   localparam logic [W-1:0]   R_OUT = 8'h00;
   localparam logic [W-1:0]   R_DIR = 8'h00;
   localparam int             ET    = EDGE_RISE;

   logic         clk        = 1'b0;
   logic         reset_n    = 1'b0;
   logic [2:0]   address    = 3'd0;
   logic         chipselect = 1'b0;
   logic         write_n    = 1'b1;
   logic [31:0]  writedata  = 32'd0;
   logic [31:0]  readdata;
   logic [W-1:0] in_port    = 8'hFF;
   logic [W-1:0] out_port;
   logic [W-1:0] oe;
   logic         irq;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   nios_pio_irq #(
      .WIDTH     (W),
      .RESET_OUT (R_OUT),
      .RESET_DIR (R_DIR),
      .EDGE_TYPE (ET)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .out_port   (out_port),
      .oe         (oe),
      .irq        (irq)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: register state updated once per clock from the bus rules.
   logic [W-1:0] m_out = R_OUT, m_dir = R_DIR, m_mask = '0, m_cap = '0, m_prev = '0;
   logic [W-1:0] m_s1 = '0, m_s2 = '0, m_in, m_nxt;
   logic [31:0]  m_rd = '0;
   bit           m_primed = 1'b0, m_wr, m_hit;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_out = R_OUT; m_dir = R_DIR; m_mask = '0; m_cap = '0;
         m_prev = '0; m_s1 = '0; m_s2 = '0; m_rd = '0; m_primed = 1'b0;
      end else begin
`ifdef PIO_IN_SYNC_EN
         m_in = m_s2; m_s2 = m_s1; m_s1 = in_port;
`else
         m_in = in_port;
`endif
         m_wr = chipselect && !write_n;
         m_rd = '0;
         case (address)
            3'd0: for (int i = 0; i < W; i++) m_rd[i] = m_dir[i] ? m_out[i] : m_in[i];
            3'd1: m_rd = 32'(m_dir);
            3'd2: m_rd = 32'(m_mask);
            3'd3: m_rd = 32'(m_cap);
            default: m_rd = '0;
         endcase
         m_nxt = m_cap;
         if (m_wr && address == 3'd3) m_nxt = m_nxt & ~writedata[W-1:0];
         if (m_primed) begin
            for (int i = 0; i < W; i++) begin
               if (ET == EDGE_RISE)      m_hit = m_in[i] && !m_prev[i];
               else if (ET == EDGE_FALL) m_hit = !m_in[i] && m_prev[i];
               else                      m_hit = m_in[i] != m_prev[i];
               if (m_hit) m_nxt[i] = 1'b1;
            end
         end
         m_cap = m_nxt;
         if (m_wr) begin
            case (address)
               3'd0: m_out = writedata[W-1:0];
               3'd1: m_dir = writedata[W-1:0];
               3'd2: m_mask = writedata[W-1:0];
               3'd4: m_out = m_out | writedata[W-1:0];
               3'd5: m_out = m_out & ~writedata[W-1:0];
               default: ;
            endcase
         end
         m_prev   = m_in;
         m_primed = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("model_out_port", 32'(out_port), 32'(m_out));
      chk("model_oe", 32'(oe), 32'(m_dir));
      chk("model_irq", 32'(irq), 32'(|(m_cap & m_mask)));
      chk("model_readdata", readdata, m_rd);
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
      address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(posedge clk); #1;
      d = readdata; chipselect = 1'b0;
   endtask

   logic [31:0] d;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_port", 32'(out_port), 32'(R_OUT));
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("prime_irq", 32'(irq), 32'd0);
      bus_read(ADDR_EDGECAP, d); chk("prime_edgecap", d, 32'h00);
      bus_read(ADDR_DATA, d);    chk("data_in_ff", d, 32'hFF);

      bus_write(ADDR_DATA, 32'hFFFF_FFA5);   chk("out_a5", 32'(out_port), 32'hA5);
      bus_write(ADDR_OUTSET, 32'h0000_000A); chk("out_af", 32'(out_port), 32'hAF);
      bus_write(ADDR_OUTCLR, 32'h0000_0081); chk("out_2e", 32'(out_port), 32'h2E);
      bus_read(ADDR_OUTSET, d);              chk("outset_rd0", d, 32'h0);

      bus_write(ADDR_DIR, 32'h0F);  chk("oe_0f", 32'(oe), 32'h0F);
      bus_write(ADDR_DATA, 32'h33);
      in_port = 8'hC0;
      bus_read(ADDR_DATA, d);       chk("data_mix_c3", d, 32'hC3);

      bus_write(ADDR_IRQMASK, 32'h01);
      in_port = 8'hC1;
      @(posedge clk); #1;
      chk("irq_on_edge", 32'(irq), 32'd1);
      bus_read(ADDR_EDGECAP, d);    chk("edgecap_01", d, 32'h01);
      bus_write(ADDR_EDGECAP, 32'h01);
      chk("irq_cleared", 32'(irq), 32'd0);

      in_port = 8'hC0;
      @(posedge clk); #1;
      in_port = 8'hC1;
      bus_write(ADDR_EDGECAP, 32'h01);
      chk("set_wins_irq", 32'(irq), 32'd1);
      bus_read(ADDR_EDGECAP, d);    chk("set_wins_cap", d, 32'h01);

      in_port = 8'h00;
      @(posedge clk); #1;
      in_port = 8'hFF;
      @(posedge clk); #1;
      bus_read(ADDR_EDGECAP, d);    chk("edgecap_ff", d, 32'hFF);
      bus_write(ADDR_DATA, 32'h55); chk("out_55_pre", 32'(out_port & oe), 32'h05);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_out", 32'(out_port), 32'(R_OUT));
      chk("midrst_oe", 32'(oe), 32'(R_DIR));
      chk("midrst_irq", 32'(irq), 32'd0);
      chk("midrst_rd", readdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus_read(ADDR_EDGECAP, d);    chk("post_rst_cap", d, 32'h00);
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nios_pio_irq.md
# nios_pio_irq

Parametrised Avalon-MM general-purpose I/O peripheral on the Nios system bus, the successor to the single-bit PIO ports. It provides a WIDTH-bit output register with per-bit direction control and bit set/clear strobes, plus an input path with per-bit edge capture and a maskable, level-sensitive interrupt to the CPU.

## Interface
- WIDTH, 8: number of I/O bits, legal range 1..32.
- RESET_OUT, 0: reset value of the output data register, WIDTH bits.
- RESET_DIR, 0: reset value of the direction register (1 = output).
- EDGE_TYPE, 0: edge that sets a capture bit: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  single system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  registered read data; bits above WIDTH are 0.
- in_port  in  WIDTH  external inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  direction register (1 = drive pin).
- irq  out  1  interrupt request, active high.

## Operation
- Register map, by word address:
  - 0 DATA: read returns, per bit, dir ? data_out : in_s; a write loads data_out.
  - 1 DIR: read/write direction.
  - 2 IRQMASK: read/write interrupt mask.
  - 3 EDGECAP: read returns the capture bits; writing a 1 clears that bit; writing 0 has no effect.
  - 4 OUTSET: write ORs writedata into data_out; reads 0.
  - 5 OUTCLR: write clears the bits of data_out selected by writedata; reads 0.
  - 6, 7: read 0; writes are ignored.
- A write occurs on a clk edge where chipselect=1 and write_n=0.
- in_s is the input as seen by the logic: in_port directly, or synchronised (see Configuration).
- prev <= in_s every cycle.
- edge_det per bit:
  - rising: in_s & ~prev.
  - falling: ~in_s & prev.
  - any: in_s ^ prev.
- edge_det is gated by the primed flag. primed resets to 0 and becomes 1 after the first clk edge, which suppresses false edges from the reset value of prev.
- Capture bits: edgecap <= (edgecap & ~clear_mask) | edge_det. When a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq = |(edgecap & irqmask). It is a combinational OR of register outputs only, with no path from in_port or the bus. irq stays asserted until software clears the capture bits or masks them.
- Reset values:
  - data_out=RESET_OUT, dir=RESET_DIR, irqmask=0, edgecap=0, prev=0, primed=0.
  - readdata=0, irq=0.
  - synchroniser flops=0.
- Reset asserted mid-operation returns every register to these values immediately; pending captures are lost.

## Timing
- readdata is registered every cycle from the current address, regardless of chipselect. Read latency is 1 cycle, so the master uses one read wait state.
- A write takes effect at the write clk edge, and out_port/oe change in the same cycle. A read in the cycle after a write returns the new value.
- Without the synchroniser, if in_port changes before edge k:
  - the capture bit and irq are 1 after edge k;
  - a DATA read presented at cycle k returns the new value after edge k.
- With PIO_IN_SYNC_EN defined, every input-path figure above is 2 cycles later.
- An input pulse must be stable for at least 1 clk (synchronised: 2 clk) to be captured. Shorter pulses may be missed.

## Configuration
- PIO_IN_SYNC_EN defined: in_s is taken from a two-flop synchroniser per bit; input latency is +2 cycles and in_port may be asynchronous.
- PIO_IN_SYNC_EN undefined: in_s = in_port, and in_port must be synchronous to clk.

## Structure
- Package nios_pio_pkg holds:
  - the address constants ADDR_DATA..ADDR_OUTCLR;
  - the edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module nios_pio_edge_det, parametrised on WIDTH and EDGE_TYPE, contains the optional synchroniser, prev, primed and edge_det.
- The top level holds the register file, the read mux and irq.

## Test plan
- Reset release with in_port=8'hFF, EDGE_TYPE=0 -> edgecap stays 0 and irq stays 0 (priming suppresses the false edge); DATA read returns 8'hFF with dir=0.
- Write DATA=8'hA5, OUTSET=8'h0A, OUTCLR=8'h81 -> out_port goes A5, then AF, then 2E, each in the write cycle; OUTSET read returns 0.
- dir=8'h0F, out=8'h33, in_port=8'hC0 -> DATA read returns 8'hC3 one cycle after address.
- irqmask=8'h01; in_port bit0 goes 0->1 -> edgecap=8'h01 and irq=1 after edge k (k+2 with PIO_IN_SYNC_EN); write EDGECAP=8'h01 -> irq=0 on the next cycle.
- A rising edge on bit0 in the same cycle as a write EDGECAP=8'h01 -> bit stays 1 and irq stays 1.
- Assert reset_n mid-run with edgecap=8'hFF and out=8'h55 -> all outputs go to their reset values asynchronously, out_port=RESET_OUT, irq=0.
